// File: rtl/ppc_loader.sv
// ppc_loader: boot-image loader for the PPC_LOAD phase.
// Optional trailer checksum is enabled by defining LOADER_CHECKSUM_EN.
`ifndef RAM_ADDR_BITS
`define RAM_ADDR_BITS 8
`endif
`ifndef RAM_ADDR_MAX
`define RAM_ADDR_MAX ((1 << `RAM_ADDR_BITS) - 1)
`endif
`ifndef PPC_LOAD
`define PPC_LOAD 2'd1
`endif
`ifndef PPC_EXEC
`define PPC_EXEC 2'd2
`endif
`ifndef PPC_FAIL
`define PPC_FAIL 2'd3
`endif

module ppc_loader (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      rx_valid,
  input  logic [7:0]                rx_data,
  output logic                      rx_ready,
  output logic [1:0]                next_state,
  output logic [5:0]                leds,
  output logic [`RAM_ADDR_BITS-1:0] ram_addr,
  output logic [3:0]                ram_byteen,
  output logic [31:0]               ram_wrdata,
  output logic                      ram_rden,
  output logic                      ram_wren,
  output logic [31:0]               words_loaded
);

  localparam int AW = `RAM_ADDR_BITS;
  localparam logic [32:0] LIMIT =
    33'(`RAM_ADDR_MAX) + 33'd1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HDR   = 3'd1,
    S_DATA  = 3'd2,
    S_WRITE = 3'd3,
    S_CSUM  = 3'd4,
    S_DONE  = 3'd5,
    S_FAIL  = 3'd6
  } state_t;

`ifdef LOADER_CHECKSUM_EN
  localparam state_t S_TAIL = S_CSUM;
`else
  localparam state_t S_TAIL = S_DONE;
`endif

  state_t          r_state;
  logic [AW-1:0]   r_ptr;
  logic [31:0]     r_count;
  logic [31:0]     r_word;
  logic [1:0]      r_bcnt;
  logic [31:0]     r_loaded;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0]     r_sum;
`endif

  logic            w_take;
  logic            w_last;
  logic [31:0]     w_cnt_sh;
  logic [31:0]     w_word_sh;
  logic [31:0]     w_loaded_inc;

  assign w_take       = rx_valid && rx_ready;
  assign w_last       = (r_bcnt == 2'd3);
  assign w_cnt_sh     = {r_count[23:0], rx_data};
  assign w_word_sh    = {r_word[23:0], rx_data};
  assign w_loaded_inc = r_loaded + 32'd1;

  // Loader FSM: header parse, word assembly, RAM write, trailer check.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_ptr    <= '0;
      r_count  <= '0;
      r_word   <= '0;
      r_bcnt   <= '0;
      r_loaded <= '0;
`ifdef LOADER_CHECKSUM_EN
      r_sum    <= '0;
`endif
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state  <= S_HDR;
            r_ptr    <= '0;
            r_bcnt   <= '0;
            r_count  <= '0;
            r_loaded <= '0;
`ifdef LOADER_CHECKSUM_EN
            r_sum    <= '0;
`endif
          end
        end
        S_HDR: begin
          if (w_take) begin
            r_count <= w_cnt_sh;
            r_bcnt  <= r_bcnt + 2'd1;
            if (w_last) begin
              if ({1'b0, w_cnt_sh} > LIMIT)
                r_state <= S_FAIL;
              else if (w_cnt_sh == 32'd0)
                r_state <= S_TAIL;
              else
                r_state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (w_take) begin
            r_word <= w_word_sh;
            r_bcnt <= r_bcnt + 2'd1;
            if (w_last)
              r_state <= S_WRITE;
          end
        end
        S_WRITE: begin
          r_loaded <= w_loaded_inc;
`ifdef LOADER_CHECKSUM_EN
          r_sum    <= r_sum + r_word;
`endif
          if (w_loaded_inc == r_count) begin
            r_state <= S_TAIL;
          end else begin
            r_ptr   <= r_ptr + 1'b1;
            r_state <= S_DATA;
          end
        end
`ifdef LOADER_CHECKSUM_EN
        S_CSUM: begin
          if (w_take) begin
            r_word <= w_word_sh;
            r_bcnt <= r_bcnt + 2'd1;
            if (w_last)
              r_state <= (w_word_sh == r_sum) ?
                         S_DONE : S_FAIL;
          end
        end
`endif
        default: r_state <= r_state;
      endcase
    end
  end

  assign rx_ready     = (r_state == S_HDR)
                     || (r_state == S_DATA)
                     || (r_state == S_CSUM);
  assign ram_wren     = (r_state == S_WRITE);
  assign ram_addr     = r_ptr;
  assign ram_wrdata   = r_word;
  assign ram_byteen   = 4'hF;
  assign ram_rden     = 1'b0;
  assign words_loaded = r_loaded;
  assign leds         = {r_ptr[2:0], r_state};

  assign next_state = (r_state == S_FAIL) ? `PPC_FAIL :
                      (r_state == S_DONE) ? `PPC_EXEC :
                                            `PPC_LOAD;

endmodule
